// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin arbiter sharing one combinational ALU among
//                N_REQ requesters; captures operands, runs one op at a time,
//                returns a registered result with valid/ready handshake.
//                Optional macro ALU_ARB_OPCHECK_EN flags illegal opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1,
    parameter int W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [3*N_REQ-1:0]   req_inst,
    input  logic [W*N_REQ-1:0]   req_da,
    input  logic [W*N_REQ-1:0]   req_db,
    output logic [N_REQ-1:0]     gnt,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [W-1:0]         rsp_data,
    output logic                 rsp_err,
    input  logic                 rsp_ready,
    output logic [2:0]           alu_inst,
    output logic [W-1:0]         alu_da,
    output logic [W-1:0]         alu_db,
    input  logic [W-1:0]         alu_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [2:0]       r_inst;
    logic [W-1:0]     r_da;
    logic [W-1:0]     r_db;
    logic [ID_W-1:0]  r_id;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [W-1:0]     r_rsp_data;
    logic             w_found;
    logic [ID_W-1:0]  w_win;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return s[ID_W-1:0];
    endfunction

    // First requester at or above the pointer, wrapping modulo N_REQ
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && req[wrap_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = wrap_idx(r_ptr, k);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (r_state == S_IDLE && w_found) gnt[w_win] = 1'b1;
    end

`ifdef ALU_ARB_OPCHECK_EN
    logic r_ill;
    logic r_rsp_err;

    function automatic logic is_illegal(input logic [2:0] op);
        return (op == 3'b010) || (op == 3'b011) || (op == 3'b111);
    endfunction

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_inst      <= 3'b000;
            r_da        <= '0;
            r_db        <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
`ifdef ALU_ARB_OPCHECK_EN
            r_ill       <= 1'b0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_inst  <= req_inst[3*int'(w_win) +: 3];
                        r_da    <= req_da[W*int'(w_win) +: W];
                        r_db    <= req_db[W*int'(w_win) +: W];
                        r_id    <= w_win;
                        r_ptr   <= wrap_idx(w_win, 1);
`ifdef ALU_ARB_OPCHECK_EN
                        r_ill   <= is_illegal(req_inst[3*int'(w_win) +: 3]);
`endif
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
`ifdef ALU_ARB_OPCHECK_EN
                    r_rsp_data <= r_ill ? '0 : alu_out;
                    r_rsp_err  <= r_ill;
`else
                    r_rsp_data <= alu_out;
`endif
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ALU inputs come straight from the capture registers so they never glitch
    assign alu_inst  = r_inst;
    assign alu_da    = r_da;
    assign alu_db    = r_db;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter (N_REQ=2) with a local
//                ALU model, vector table and response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [5:0]  req_inst;
    logic [63:0] req_da;
    logic [63:0] req_db;
    logic [1:0]  gnt;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_ready;
    logic [2:0]  alu_inst;
    logic [31:0] alu_da;
    logic [31:0] alu_db;
    logic [31:0] alu_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    alu_arbiter #(.N_REQ(2), .ID_W(1), .W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .req_inst(req_inst), .req_da(req_da),
        .req_db(req_db), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .alu_inst(alu_inst), .alu_da(alu_da), .alu_db(alu_db), .alu_out(alu_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a + b;
            3'b101:  return a - b;
            3'b100:  return a & b;
            3'b001:  return a | b;
            3'b110:  return a ^ b;
            default: return 32'h0BAD_0BAD;
        endcase
    endfunction

    // The shared ALU the arbiter fronts
    always_comb alu_out = ref_alu(alu_inst, alu_da, alu_db);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t predict(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.id = id;
`ifdef ALU_ARB_OPCHECK_EN
        e.err  = (op == 3'b010) || (op == 3'b011) || (op == 3'b111);
        e.data = e.err ? 32'h0 : ref_alu(op, a, b);
`else
        e.err  = 1'b0;
        e.data = ref_alu(op, a, b);
`endif
        return e;
    endfunction

    // Push on acceptance, pop on the response handshake
    always @(negedge clk) begin
        if (!rst && gnt != 2'b00) begin
            int id;
            id = gnt[1] ? 1 : 0;
            chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
            chk("gnt_has_req", 32'(req[id]), 32'd1);
            sb.push_back(predict(id, req_inst[3*id +: 3], req_da[32*id +: 32], req_db[32*id +: 32]));
        end
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got response id %0d data %h expected none", rsp_id, rsp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_id", 32'(rsp_id), 32'(e.id));
                chk("sb_data", rsp_data, e.data);
                chk("sb_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        sb.delete();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_op(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_inst[3*idx +: 3] = op;
        req_da[32*idx +: 32] = a;
        req_db[32*idx +: 32] = b;
    endtask

    // Leaves the caller at the negedge of the grant cycle
    task automatic wait_gnt(output bit got);
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if (gnt != 2'b00) got = 1'b1;
            else next_cycle();
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: got no grant expected a grant within 12 cycles");
        end
    endtask

    typedef struct {
        int          idx;
        logic [2:0]  inst;
        logic [31:0] da;
        logic [31:0] db;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit          got;
        logic [1:0]  eg;
        logic [31:0] hold_data;
        logic [0:0]  hold_id;
        int          last;

        vecs[0] = '{0, 3'b000, 32'd5,        32'd7,        32'd12,         1'b0};
        vecs[1] = '{1, 3'b101, 32'd3,        32'd5,        32'hFFFF_FFFE,  1'b0};
        vecs[2] = '{0, 3'b100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0};
        vecs[3] = '{1, 3'b001, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0};
        vecs[4] = '{0, 3'b110, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0};
        vecs[5] = '{1, 3'b000, 32'hFFFF_FFFF, 32'd1,        32'd0,          1'b0};
`ifdef ALU_ARB_OPCHECK_EN
        vecs[6] = '{0, 3'b011, 32'd1,        32'd2,        32'd0,          1'b1};
`else
        vecs[6] = '{0, 3'b011, 32'd1,        32'd2,        32'h0BAD_0BAD,  1'b0};
`endif
        vecs[7] = '{1, 3'b101, 32'd0,        32'd1,        32'hFFFF_FFFF,  1'b0};

        rst = 1'b1; req = 2'b00; req_inst = '0; req_da = '0; req_db = '0; rsp_ready = 1'b1;
        do_reset();
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_alu_inst", 32'(alu_inst), 32'd0);
        chk("rst_alu_da", alu_da, 32'd0);
        chk("rst_alu_db", alu_db, 32'd0);
        next_cycle();

        // Single-requester vectors: grant at T, response at T+2
        for (int v = 0; v < 8; v++) begin
            set_op(vecs[v].idx, vecs[v].inst, vecs[v].da, vecs[v].db);
            eg = 2'b01 << vecs[v].idx;
            req = eg;
            wait_gnt(got);
            chk("vec_gnt", 32'(gnt), 32'(eg));
            next_cycle();
            req = 2'b00;
            @(negedge clk);
            chk("vec_exec_valid", 32'(rsp_valid), 32'd0);
            chk("vec_exec_alu_da", alu_da, vecs[v].da);
            next_cycle();
            @(negedge clk);
            chk("vec_valid", 32'(rsp_valid), 32'd1);
            chk("vec_id", 32'(rsp_id), 32'(vecs[v].idx));
            chk("vec_data", rsp_data, vecs[v].exp_data);
            chk("vec_err", 32'(rsp_err), 32'(vecs[v].exp_err));
            next_cycle();
            @(negedge clk);
            chk("vec_alu_hold", alu_db, vecs[v].db);
            next_cycle();
        end

        // Both requesting continuously: alternate 0,1,0,1 at 3-cycle spacing
        do_reset();
        set_op(0, 3'b000, 32'd1, 32'd2);
        set_op(1, 3'b110, 32'd3, 32'd5);
        req = 2'b11;
        last = 0;
        for (int g = 0; g < 4; g++) begin
            wait_gnt(got);
            eg = 2'b01 << (g % 2);
            chk("rr_gnt", 32'(gnt), 32'(eg));
            if (g > 0) chk("rr_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            next_cycle();
        end
        req = 2'b00;
        repeat (4) next_cycle();

        // Back-pressure in RESP: outputs hold, no grant despite requests
        rsp_ready = 1'b0;
        req = 2'b11;
        wait_gnt(got);
        chk("bp_gnt", 32'(gnt), 32'd1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        hold_data = rsp_data;
        hold_id   = rsp_id;
        chk("bp_data_first", hold_data, 32'd3);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data_stable", rsp_data, hold_data);
            chk("bp_id_stable", 32'(rsp_id), 32'(hold_id));
            chk("bp_no_gnt", 32'(gnt), 32'd0);
            next_cycle();
            @(negedge clk);
        end
        next_cycle();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_no_gnt", 32'(gnt), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("bp_next_gnt", 32'(gnt), 32'd2);
        next_cycle();
        req = 2'b00;
        repeat (4) next_cycle();

        // Reset mid-op: in-flight op discarded, pointer back to 0
        req = 2'b01;
        wait_gnt(got);
        chk("rst_mid_gnt", 32'(gnt), 32'd1);
        next_cycle();
        req = 2'b00;
        rst = 1'b1;
        sb.delete();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_data", rsp_data, 32'd0);
        chk("rst_mid_alu_inst", 32'(alu_inst), 32'd0);
        chk("rst_mid_alu_da", alu_da, 32'd0);
        next_cycle();
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst_mid_idle_valid", 32'(rsp_valid), 32'd0);
        next_cycle();
        req = 2'b11;
        @(negedge clk);
        chk("rst_mid_ptr0", 32'(gnt), 32'd1);
        next_cycle();
        req = 2'b00;
        repeat (4) next_cycle();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
